// File: rtl/synchronous_fifo_pkg.sv
// Default geometry shared by the FIFO top and its storage sub-module.
package synchronous_fifo_pkg;
   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_WIDTH = 8;
endpackage

// File: rtl/synchronous_fifo_mem.sv
// DEPTH x WIDTH storage for the FIFO: one write port and one registered read port.
module synchronous_fifo_mem
   import synchronous_fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int WIDTH      = FIFO_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately left out of reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: wrap-bit pointers, combinational full/empty flags and a
// registered error pulse for rejected writes (when full) or reads (when empty).
module synchronous_fifo
   import synchronous_fifo_pkg::*;
#(
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int WIDTH     = FIFO_WIDTH,
   parameter int PTR_WIDTH = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic             rd_en_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             error_o
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

   logic [PTR_WIDTH:0] wr_ptr;
   logic [PTR_WIDTH:0] rd_ptr;
   logic               wr_accept;
   logic               rd_accept;

   // The extra MSB separates "same slot, same lap" (empty) from "same slot, one lap ahead" (full).
   assign empty_o   = (wr_ptr == rd_ptr);
   assign full_o    = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                      (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
   assign wr_accept = wr_en_i && !full_o;
   assign rd_accept = rd_en_i && !empty_o;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         error_o <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         error_o <= (wr_en_i && full_o) || (rd_en_i && empty_o);
      end
   end

   synchronous_fifo_mem #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .ADDR_WIDTH(PTR_WIDTH)
   ) u_mem (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_en  (wr_accept),
      .wr_addr(wr_ptr[PTR_WIDTH-1:0]),
      .wdata  (wdata_i),
      .rd_en  (rd_accept),
      .rd_addr(rd_ptr[PTR_WIDTH-1:0]),
      .rdata  (rdata_o)
   );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed bench for synchronous_fifo: a queue model predicts flags, error pulses
// and read data; predicted read data is pushed to a scoreboard and popped on output.
module tb_synchronous_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             wr_en_i = 1'b0;
   logic             rd_en_i = 1'b0;
   logic [WIDTH-1:0] wdata_i = '0;
   logic             full_o;
   logic [WIDTH-1:0] rdata_o;
   logic             empty_o;
   logic             error_o;

   int               n_checks = 0;
   int               n_fail = 0;
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] held_rdata = '0;
   logic             exp_err = 1'b0;
   logic             rd_ok = 1'b0;

   synchronous_fifo #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .PTR_WIDTH(4)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_en_i(wr_en_i),
      .rd_en_i(rd_en_i),
      .wdata_i(wdata_i),
      .full_o (full_o),
      .rdata_o(rdata_o),
      .empty_o(empty_o),
      .error_o(error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag);
      check_output({tag, "_empty"}, {7'd0, empty_o}, {7'd0, model_q.size() == 0});
      check_output({tag, "_full"}, {7'd0, full_o}, {7'd0, model_q.size() == DEPTH});
   endtask

   // One clock of stimulus; the model is advanced using the occupancy seen at that edge.
   task automatic apply_stimulus(input string tag, input logic wr, input logic rd,
                                 input logic [WIDTH-1:0] data);
      logic wr_ok;
      @(negedge clk_i);
      wr_en_i = wr;
      rd_en_i = rd;
      wdata_i = data;
      exp_err = (wr && model_q.size() == DEPTH) || (rd && model_q.size() == 0);
      wr_ok   = wr && model_q.size() < DEPTH;
      rd_ok   = rd && model_q.size() > 0;
      if (rd_ok) exp_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(data);
      @(posedge clk_i);
      #1;
      check_output({tag, "_error"}, {7'd0, error_o}, {7'd0, exp_err});
      check_flags(tag);
      if (rd_ok) held_rdata = exp_q.pop_front();
      check_output({tag, "_rdata"}, rdata_o, held_rdata);
   endtask

   initial begin
      logic [WIDTH-1:0] d;

      // Reset held for two cycles
      repeat (2) @(posedge clk_i);
      #1;
      check_flags("reset");
      check_output("reset_error", {7'd0, error_o}, 8'd0);
      check_output("reset_rdata", rdata_o, 8'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Fill with random bytes
      for (int i = 0; i < DEPTH; i++) begin
         d = WIDTH'($urandom_range(0, 255));
         apply_stimulus("fill", 1'b1, 1'b0, d);
      end

      // Overflow write, then error must clear on the next idle edge
      apply_stimulus("overflow", 1'b1, 1'b0, 8'hAA);
      apply_stimulus("overflow_idle", 1'b0, 1'b0, 8'h00);

      // Drain in write order, then one read too many
      for (int i = 0; i < DEPTH; i++) apply_stimulus("drain", 1'b0, 1'b1, 8'h00);
      apply_stimulus("underflow", 1'b0, 1'b1, 8'h00);
      apply_stimulus("underflow_idle", 1'b0, 1'b0, 8'h00);

      // Simultaneous read/write on empty: write proceeds, read rejected
      apply_stimulus("simul_empty", 1'b1, 1'b1, 8'h3C);
      for (int i = 0; i < 4; i++) apply_stimulus("preload", 1'b1, 1'b0, WIDTH'(8'h10 + i));
      for (int i = 0; i < 20; i++) begin
         d = WIDTH'($urandom_range(0, 255));
         apply_stimulus("simul", 1'b1, 1'b1, d);
      end

      // Top up to full, then simultaneous access: read proceeds, write rejected
      for (int i = 0; i < DEPTH - 5; i++) apply_stimulus("topup", 1'b1, 1'b0, WIDTH'(8'h80 + i));
      apply_stimulus("simul_full", 1'b1, 1'b1, 8'h55);
      apply_stimulus("refill", 1'b1, 1'b0, 8'h66);

      // Async reset between edges while partially full
      for (int i = 0; i < 8; i++) apply_stimulus("half_drain", 1'b0, 1'b1, 8'h00);
      @(negedge clk_i);
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      #2;
      rst_i = 1'b0;
      #1;
      model_q.delete();
      exp_q.delete();
      held_rdata = '0;
      check_flags("async_reset");
      check_output("async_reset_rdata", rdata_o, 8'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Behaves as from empty afterwards
      apply_stimulus("post_reset_rd", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 3; i++) apply_stimulus("post_reset_wr", 1'b1, 1'b0, WIDTH'(8'hC0 + i));
      for (int i = 0; i < 3; i++) apply_stimulus("post_reset_drain", 1'b0, 1'b1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
